// File: rtl/tile_flip_ctrl.sv
// rtl/tile_flip_ctrl.sv - sequencing controller for the 4x4 tile-flip memory game
module tile_flip_ctrl #(
  parameter int MISMATCH_CYCLES = 25000000,
  parameter int MOVE_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_game,
  input  logic [63:0]       tile_symbols,
  input  logic              select_valid,
  input  logic [3:0]        select_idx,
  output logic              select_ready,
  output logic [15:0]       game_state,
  output logic [15:0]       matched_tiles,
  output logic [15:0]       mismatched_tiles,
  output logic [MOVE_W-1:0] move_count,
  output logic              game_won
);

  localparam int TW = $clog2(MISMATCH_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_FIRST,
    S_SECOND,
    S_COMPARE,
    S_SHOW_MISS,
    S_WON
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       sym_q, sym_d;
  logic [3:0]        first_q, first_d;
  logic [3:0]        second_q, second_d;
  logic [15:0]       up_q, up_d;
  logic [15:0]       matched_q, matched_d;
  logic [15:0]       miss_q, miss_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic        accept;
  logic [15:0] pair_mask;
  logic [3:0]  first_sym;
  logic [3:0]  second_sym;

  // Outputs come straight from registers (or decode of the state register).
  assign select_ready     = (state_q == S_FIRST) || (state_q == S_SECOND);
  assign game_won         = (state_q == S_WON);
  assign game_state       = up_q;
  assign matched_tiles    = matched_q;
  assign mismatched_tiles = miss_q;
  assign move_count       = move_q;

  assign accept     = select_valid && select_ready && !up_q[select_idx] && !matched_q[select_idx];
  assign pair_mask  = (16'd1 << first_q) | (16'd1 << second_q);
  assign first_sym  = sym_q[{first_q, 2'b00} +: 4];
  assign second_sym = sym_q[{second_q, 2'b00} +: 4];

  // Next-state and board-update logic; new_game overrides everything else.
  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    first_d   = first_q;
    second_d  = second_q;
    up_d      = up_q;
    matched_d = matched_q;
    miss_d    = miss_q;
    move_d    = move_q;
    timer_d   = timer_q;

    if (new_game) begin
      state_d   = S_FIRST;
      sym_d     = tile_symbols;
      up_d      = '0;
      matched_d = '0;
      miss_d    = '0;
      move_d    = '0;
      timer_d   = '0;
    end else begin
      case (state_q)
        S_FIRST: begin
          if (accept) begin
            up_d[select_idx] = 1'b1;
            first_d          = select_idx;
            state_d          = S_SECOND;
          end
        end
        S_SECOND: begin
          if (accept) begin
            up_d[select_idx] = 1'b1;
            second_d         = select_idx;
            state_d          = S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (move_q != '1) begin
            move_d = move_q + 1'b1;
          end
          if (first_sym == second_sym) begin
            matched_d = matched_q | pair_mask;
            state_d   = ((matched_q | pair_mask) == 16'hFFFF) ? S_WON : S_FIRST;
          end else begin
            miss_d  = pair_mask;
            timer_d = TW'(MISMATCH_CYCLES - 1);
            state_d = S_SHOW_MISS;
          end
        end
        S_SHOW_MISS: begin
          if (timer_q == '0) begin
            up_d    = up_q & ~pair_mask;
            miss_d  = miss_q & ~pair_mask;
            state_d = S_FIRST;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_WON: begin
          state_d = S_WON;
        end
        default: begin
          state_d = S_FIRST;
        end
      endcase
    end
  end

  // State and board registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FIRST;
      sym_q     <= '0;
      first_q   <= '0;
      second_q  <= '0;
      up_q      <= '0;
      matched_q <= '0;
      miss_q    <= '0;
      move_q    <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      sym_q     <= sym_d;
      first_q   <= first_d;
      second_q  <= second_d;
      up_q      <= up_d;
      matched_q <= matched_d;
      miss_q    <= miss_d;
      move_q    <= move_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: tb/tb_tile_flip_ctrl.sv
// tb/tb_tile_flip_ctrl.sv - directed self-checking bench for tile_flip_ctrl
module tb_tile_flip_ctrl;

  // tile i symbol = i/2, so pairs are (0,1),(2,3),...
  localparam logic [63:0] MAP_WIN  = 64'h7766_5544_3322_1100;
  // tile0=tile1=3, tile2=5, tile3=6, tile4=6, tile5=5, rest paired
  localparam logic [63:0] MAP_MISS = 64'h8877_4422_1156_6533;

  logic        clk;
  logic        reset;
  logic        new_game;
  logic [63:0] tile_symbols;
  logic        select_valid;
  logic [3:0]  select_idx;

  logic        select_ready, select_ready2;
  logic [15:0] game_state, game_state2;
  logic [15:0] matched_tiles, matched_tiles2;
  logic [15:0] mismatched_tiles, mismatched_tiles2;
  logic [7:0]  move_count;
  logic [1:0]  move_count2;
  logic        game_won, game_won2;

  int checks;
  int errors;

  tile_flip_ctrl #(.MISMATCH_CYCLES(4), .MOVE_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_game         (new_game),
    .tile_symbols     (tile_symbols),
    .select_valid     (select_valid),
    .select_idx       (select_idx),
    .select_ready     (select_ready),
    .game_state       (game_state),
    .matched_tiles    (matched_tiles),
    .mismatched_tiles (mismatched_tiles),
    .move_count       (move_count),
    .game_won         (game_won)
  );

  tile_flip_ctrl #(.MISMATCH_CYCLES(4), .MOVE_W(2)) dut_sat (
    .clk              (clk),
    .reset            (reset),
    .new_game         (new_game),
    .tile_symbols     (tile_symbols),
    .select_valid     (select_valid),
    .select_idx       (select_idx),
    .select_ready     (select_ready2),
    .game_state       (game_state2),
    .matched_tiles    (matched_tiles2),
    .mismatched_tiles (mismatched_tiles2),
    .move_count       (move_count2),
    .game_won         (game_won2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [63:0] map);
    new_game     = 1'b1;
    tile_symbols = map;
    tick();
    new_game     = 1'b0;
    tile_symbols = 64'h0;
  endtask

  task automatic sel(input logic [3:0] idx);
    select_valid = 1'b1;
    select_idx   = idx;
    tick();
    select_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({game_state, matched_tiles, mismatched_tiles} !== 48'h0) begin
      errors++;
      $display("FAIL reset_vectors: got %h expected 0", {game_state, matched_tiles, mismatched_tiles});
    end
    checks++;
    if ({move_count, game_won} !== 9'h0) begin
      errors++;
      $display("FAIL reset_move_won: got %h expected 0", {move_count, game_won});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (select_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", select_ready);
    end
  endtask

  task automatic test_match();
    start_game(MAP_MISS);
    sel(4'd0);
    checks++;
    if ({game_state, matched_tiles, select_ready} !== {16'h0001, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL match_first: got %h expected %h", {game_state, matched_tiles, select_ready}, {16'h0001, 16'h0000, 1'b1});
    end
    sel(4'd1);
    checks++;
    if ({game_state, matched_tiles, select_ready} !== {16'h0003, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL match_compare: got %h expected %h", {game_state, matched_tiles, select_ready}, {16'h0003, 16'h0000, 1'b0});
    end
    tick();
    checks++;
    if ({matched_tiles, move_count, select_ready} !== {16'h0003, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL match_result: got %h expected %h", {matched_tiles, move_count, select_ready}, {16'h0003, 8'd1, 1'b1});
    end
  endtask

  task automatic test_reselect();
    sel(4'd0);
    tick();
    checks++;
    if ({game_state, matched_tiles, mismatched_tiles, move_count, select_ready} !==
        {16'h0003, 16'h0003, 16'h0000, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL reselect: got %h expected %h",
               {game_state, matched_tiles, mismatched_tiles, move_count, select_ready},
               {16'h0003, 16'h0003, 16'h0000, 8'd1, 1'b1});
    end
  endtask

  task automatic test_mismatch();
    int n;
    sel(4'd2);
    sel(4'd3);
    checks++;
    if ({game_state, mismatched_tiles} !== {16'h000F, 16'h0000}) begin
      errors++;
      $display("FAIL miss_compare: got %h expected %h", {game_state, mismatched_tiles}, {16'h000F, 16'h0000});
    end
    tick();
    checks++;
    if ({mismatched_tiles, move_count, select_ready} !== {16'h000C, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL miss_shown: got %h expected %h", {mismatched_tiles, move_count, select_ready}, {16'h000C, 8'd2, 1'b0});
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      select_valid = (i == 0);
      select_idx   = 4'd4;
      tick();
      select_valid = 1'b0;
      if (mismatched_tiles == 16'h000C) n++;
      else break;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL miss_duration: got %0d cycles expected 4", n);
    end
    checks++;
    if ({game_state, mismatched_tiles, move_count, select_ready} !== {16'h0003, 16'h0000, 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL miss_flipback: got %h expected %h",
               {game_state, mismatched_tiles, move_count, select_ready}, {16'h0003, 16'h0000, 8'd2, 1'b1});
    end
  endtask

  task automatic test_new_game_priority();
    new_game     = 1'b1;
    tile_symbols = MAP_MISS;
    select_valid = 1'b1;
    select_idx   = 4'd4;
    tick();
    new_game     = 1'b0;
    select_valid = 1'b0;
    checks++;
    if ({game_state, matched_tiles, move_count, select_ready} !== {16'h0, 16'h0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL newgame_priority: got %h expected %h",
               {game_state, matched_tiles, move_count, select_ready}, {16'h0, 16'h0, 8'd0, 1'b1});
    end
    tick();
    checks++;
    if (game_state !== 16'h0) begin
      errors++;
      $display("FAIL newgame_dropped_select: got %h expected 0000", game_state);
    end
  endtask

  task automatic test_win();
    start_game(MAP_WIN);
    for (int k = 0; k < 8; k++) begin
      sel(4'(2 * k));
      sel(4'(2 * k + 1));
      tick();
      if (k == 6) begin
        checks++;
        if ({matched_tiles, game_won} !== {16'h3FFF, 1'b0}) begin
          errors++;
          $display("FAIL win_almost: got %h expected %h", {matched_tiles, game_won}, {16'h3FFF, 1'b0});
        end
      end
    end
    checks++;
    if ({game_state, matched_tiles, game_won, select_ready, move_count} !== {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 8'd8}) begin
      errors++;
      $display("FAIL win_final: got %h expected %h",
               {game_state, matched_tiles, game_won, select_ready, move_count}, {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 8'd8});
    end
    sel(4'd0);
    tick();
    checks++;
    if ({matched_tiles, game_won, move_count} !== {16'hFFFF, 1'b1, 8'd8}) begin
      errors++;
      $display("FAIL win_hold: got %h expected %h", {matched_tiles, game_won, move_count}, {16'hFFFF, 1'b1, 8'd8});
    end
  endtask

  task automatic test_saturation();
    bit ok;
    start_game(MAP_MISS);
    for (int m = 0; m < 5; m++) begin
      sel(4'd2);
      sel(4'd3);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (select_ready) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sat_timeout: mismatch %0d never returned to ready", m);
      end
    end
    checks++;
    if (move_count2 !== 2'd3) begin
      errors++;
      $display("FAIL sat_move2: got %0d expected 3", move_count2);
    end
    checks++;
    if (move_count !== 8'd5) begin
      errors++;
      $display("FAIL sat_move8: got %0d expected 5", move_count);
    end
  endtask

  task automatic test_reset_mid_miss();
    start_game(MAP_MISS);
    sel(4'd2);
    sel(4'd3);
    tick();
    checks++;
    if (mismatched_tiles !== 16'h000C) begin
      errors++;
      $display("FAIL rst_mid_setup: got %h expected 000c", mismatched_tiles);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({game_state, matched_tiles, mismatched_tiles, move_count, game_won, select_ready} !==
        {16'h0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected %h",
               {game_state, matched_tiles, mismatched_tiles, move_count, game_won, select_ready},
               {16'h0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b1});
    end
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if ({select_ready, move_count, game_state} !== {1'b1, 8'd0, 16'h0}) begin
      errors++;
      $display("FAIL rst_mid_release: got %h expected %h", {select_ready, move_count, game_state}, {1'b1, 8'd0, 16'h0});
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    new_game     = 1'b0;
    tile_symbols = 64'h0;
    select_valid = 1'b0;
    select_idx   = 4'd0;
    test_reset();
    test_match();
    test_reselect();
    test_mismatch();
    test_new_game_priority();
    test_win();
    test_saturation();
    test_reset_mid_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_flip_ctrl.md
Name: tile_flip_ctrl

Overview:
Game-sequencing controller for the 4x4 tile-flip memory game. It accepts player tile selections and compares each pair of flipped tiles against a latched symbol map. It drives the three 16-bit tile-status vectors consumed by the VGA tile renderer: face-up, matched and mismatched. It also times the mismatch display, counts moves and flags game completion.

Parameters:
MISMATCH_CYCLES, 25000000, clk cycles a mismatched pair stays shown before flipping back (1 s at 25 MHz); must be >= 1
MOVE_W, 8, width of move counter

Ports:
clk  input  1  pixel/system clock
reset  input  1  asynchronous, active-low reset
new_game  input  1  single-cycle pulse; clears board and latches tile_symbols
tile_symbols  input  64  4-bit symbol per tile, tile i at [4i+3:4i]; each symbol appears on exactly two tiles
select_valid  input  1  player selection strobe
select_idx  input  4  selected tile index (row*4+col)
select_ready  output  1  high when a selection can be accepted
game_state  output  16  1 = tile face-up
matched_tiles  output  16  1 = tile permanently matched
mismatched_tiles  output  16  1 = tile in currently shown mismatched pair
move_count  output  MOVE_W  number of completed pair comparisons, saturating
game_won  output  1  high once all 16 tiles are matched

Behaviour:
- Reset (reset low, async):
  - state=FIRST; all 16-bit outputs 0; move_count 0; game_won 0; timer 0.
  - Latched symbol map is cleared to 0.
  - Outputs are registered; select_ready=1 after reset release.
- States: FIRST, SECOND, COMPARE, SHOW_MISS, WON.
- select_ready is 1 in FIRST and SECOND only.
- Selection acceptance:
  - Accepted when select_valid & select_ready & game_state[select_idx]==0 & matched_tiles[select_idx]==0.
  - Invalid selections (tile already up or matched, or while not ready) are dropped silently, with no state change.
- FIRST, accepted select:
  - game_state[idx]<=1 and idx stored as first; next state SECOND.
  - The bit is visible on the cycle after acceptance.
- SECOND, accepted select:
  - game_state[idx]<=1 and idx stored as second; next state COMPARE.
- COMPARE (exactly 1 cycle):
  - move_count increments, saturating at all-ones.
  - Symbols equal: matched bits for both tiles <=1; game_state bits stay 1. Next state WON if the matched vector including this pair is all-ones, else FIRST.
  - Symbols differ: mismatched bits for both <=1; timer <= MISMATCH_CYCLES-1; next state SHOW_MISS.
  - Matched/mismatched bits are visible 2 cycles after the second selection is accepted.
- SHOW_MISS:
  - Timer decrements each cycle.
  - On the cycle the timer equals 0: clear game_state and mismatched_tiles bits of both tiles; next state FIRST.
  - Mismatch is therefore shown for exactly MISMATCH_CYCLES cycles.
- WON:
  - game_won=1; select_ready=0; outputs hold until new_game or reset.
- new_game pulse (any state, synchronous):
  - Next cycle: state FIRST; game_state, matched_tiles, mismatched_tiles, move_count, game_won all 0; timer 0.
  - tile_symbols is latched.
  - new_game has priority over a same-cycle select, which is dropped.
- The compare always uses the latched map; changes on tile_symbols between new_game pulses have no effect.
- Same-index second selection cannot occur, because that tile is already face-up and the selection is rejected.
- Invariants:
  - matched_tiles and mismatched_tiles are subsets of game_state.
  - matched_tiles & mismatched_tiles == 0.
  - popcount(mismatched_tiles) is 0 or 2.
- Timer width: clog2(MISMATCH_CYCLES)+1 bits.

Test Plan:
- Reset low mid-SHOW_MISS -> all outputs 0 immediately; after release select_ready=1, move_count=0.
- MISMATCH_CYCLES=4; new_game with symbols tile0=tile1=3:
  - select 0 -> game_state=0x0001 next cycle.
  - select 1 -> matched_tiles=0x0003 two cycles later; move_count=1; back in FIRST.
- Same bench, tile2=5, tile3=6:
  - select 2, then 3 -> mismatched_tiles=0x000C for exactly 4 cycles.
  - Then game_state and mismatched drop to 0x0003 and 0x0000; move_count=2.
  - A select during that window is ignored.
- Re-select a face-up tile (select 0 after the match) -> no change to any output; move_count unchanged.
- Match all 8 pairs in order -> matched_tiles=0xFFFF, game_won=1, select_ready=0, move_count=8; further selects ignored.
- new_game asserted in the same cycle as select_valid (idx 4) in FIRST -> game_state=0 next cycle, select dropped.
- With move_count saturation (MOVE_W=2): 5 mismatches -> move_count holds at 3.
